// File: rtl/self_test_pkg.sv
// Shared constants, field positions and receiver state type for the
// per-layer sort / self-test chain controller.
package self_test_pkg;

    // Serial protocol constants
    localparam logic [15:0] SYNC = 16'h0DF0;
    localparam logic [3:0]  PASS = 4'hA;
    localparam logic [15:0] TAIL = 16'hBEAF;
    localparam int          DLY  = 5;

    // Frame geometry (bit positions inside the assembled 32-bit word)
    localparam int FRAME_BITS = 32;
    localparam int TP_LSB     = 28;   // test_pass [31:28]
    localparam int PS_LSB     = 24;   // power_set [27:24]
    localparam int IA_LSB     = 20;   // ID_above  [23:20]
    localparam int IL_LSB     = 16;   // ID_layer  [19:16]
    localparam int TR_MSB     = 15;   // trailer   [15:0]

    // Serial positions (0 = first bit on the wire) of the last bit of the
    // test_pass and ID_above nibbles.
    localparam int TP_LAST_BIT  = 3;
    localparam int IA_FIRST_BIT = 8;
    localparam int IA_LAST_BIT  = 11;

    // Bit counter value at which the first ID_above bit leaves the delay line
    localparam int SUB_FIRST = IA_FIRST_BIT + DLY;

    // Stream emitted by the bottom layer: SYNC then a frame naming layer 1
    localparam int          ORIG_BITS = 48;
    localparam logic [47:0] ORIG_ROM  = {SYNC, PASS, 4'h0, 4'h0, 4'h1, TAIL};

    typedef enum logic {
        HUNT  = 1'b0,
        FRAME = 1'b1
    } rx_state_e;

    // Layer IDs are 4-bit and wrap from F back to 0
    function automatic logic [3:0] next_id(input logic [3:0] id);
        return id + 4'd1;
    endfunction

endpackage

// File: rtl/serial_frame_rx.sv
// Serial receiver: hunts for SYNC, then counts 32-bit frames back-to-back.
// Field outputs and the valid strobe are combinational so the top can act on
// the same edge that samples the final trailer bit.
module serial_frame_rx
    import self_test_pkg::*;
(
    input  logic       t_clk,
    input  logic       rst_n,
    input  logic       data_i,
    output logic       in_frame_o,
    output logic [4:0] bit_cnt_o,
    output logic       pass_ok_o,
    output logic [3:0] sub_id_above_o,
    output logic       frame_valid_o,
    output logic [3:0] frame_id_above_o,
    output logic [3:0] frame_power_o,
    output logic [3:0] frame_id_layer_o
);

    rx_state_e   state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [30:0] shift_q;
    logic [3:0]  pass_q, pass_d;
    logic [3:0]  ia_q, ia_d;

    // Last 31 samples plus the bit on the wire right now; at bit 31 this is
    // the whole frame, in HUNT its low 16 bits are the sync window.
    logic [31:0] word;
    logic        frame_end;

    assign word      = {shift_q, data_i};
    assign frame_end = (state_q == FRAME) && (cnt_q == 5'(FRAME_BITS - 1));

    assign frame_valid_o    = frame_end
                              && (word[TP_LSB +: 4] == PASS)
                              && (word[TR_MSB:0] == TAIL);
    assign frame_id_above_o = word[IA_LSB +: 4];
    assign frame_power_o    = word[PS_LSB +: 4];
    assign frame_id_layer_o = word[IL_LSB +: 4];

    assign in_frame_o     = (state_q == FRAME);
    assign bit_cnt_o      = cnt_q;
    assign pass_ok_o      = (pass_q == PASS);
    assign sub_id_above_o = ia_q;

    // Next-state: sync hunt, bit counting and early nibble capture
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pass_d  = pass_q;
        ia_d    = ia_q;
        case (state_q)
            HUNT: begin
                if (word[15:0] == SYNC) begin
                    state_d = FRAME;
                    cnt_d   = 5'd0;
                end
            end
            FRAME: begin
                if (cnt_q == 5'(TP_LAST_BIT)) begin
                    pass_d = word[3:0];
                end
                if (cnt_q == 5'(IA_LAST_BIT)) begin
                    ia_d = word[3:0];
                end
                if (frame_end) begin
                    cnt_d = 5'd0;
                    if (!frame_valid_o) begin
                        state_d = HUNT;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            default: state_d = HUNT;
        endcase
    end

    // Receiver registers; the input shifter runs every cycle in both states
    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HUNT;
            cnt_q   <= 5'd0;
            shift_q <= '0;
            pass_q  <= 4'd0;
            ia_q    <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= word[30:0];
            pass_q  <= pass_d;
            ia_q    <= ia_d;
        end
    end

endmodule

// File: rtl/self_test_top.sv
// Per-layer sort / self-test controller. A non-bottom layer derives its ID
// from the frame sent by the layer below, latches its power setting, and
// forwards the stream upward with its own ID patched into ID_above. The
// bottom layer originates the stream from a small ROM instead.
module self_test_top
    import self_test_pkg::*;
(
    input  logic t_clk,
    input  logic rst_n,
    input  logic f_layer,
    input  logic data_in,
    output logic sort_finish,
    output logic data_out
);

    logic           mode_valid_q;
    logic           is_first_q;
    logic [DLY-1:0] dly_q;
    logic           data_out_q, data_out_d;
    logic           sort_finish_q, sort_finish_d;
    logic [3:0]     own_id_q, own_id_d;
    logic [3:0]     power_reg_q, power_reg_d;
    logic [5:0]     orig_cnt_q, orig_cnt_d;

    logic       rx_in_frame;
    logic [4:0] rx_cnt;
    logic       rx_pass_ok;
    logic [3:0] rx_sub_ia;
    logic       rx_valid;
    logic [3:0] rx_frame_ia;
    logic [3:0] rx_power;
    logic [3:0] rx_id_layer;

    serial_frame_rx u_rx (
        .t_clk            (t_clk),
        .rst_n            (rst_n),
        .data_i           (data_in),
        .in_frame_o       (rx_in_frame),
        .bit_cnt_o        (rx_cnt),
        .pass_ok_o        (rx_pass_ok),
        .sub_id_above_o   (rx_sub_ia),
        .frame_valid_o    (rx_valid),
        .frame_id_above_o (rx_frame_ia),
        .frame_power_o    (rx_power),
        .frame_id_layer_o (rx_id_layer)
    );

    // The ID_above nibble leaves the delay line while the counter sits at
    // SUB_FIRST..SUB_FIRST+3; by then the nibble has been fully received.
    logic       sub_active;
    logic [1:0] sub_sel;
    logic [3:0] sub_id;
    logic       sub_bit;

    assign sub_active = rx_in_frame && rx_pass_ok
                        && (rx_cnt >= 5'(SUB_FIRST))
                        && (rx_cnt <  5'(SUB_FIRST + 4));
    assign sub_sel    = 2'(rx_cnt - 5'(SUB_FIRST));
    assign sub_id     = sort_finish_q ? own_id_q : next_id(rx_sub_ia);
    assign sub_bit    = sub_id[2'd3 - sub_sel];

    // Next-state for outputs, ID/power registers and the originator counter
    always_comb begin
        data_out_d    = 1'b0;
        sort_finish_d = sort_finish_q;
        own_id_d      = own_id_q;
        power_reg_d   = power_reg_q;
        orig_cnt_d    = orig_cnt_q;
        if (mode_valid_q) begin
            if (is_first_q) begin
                if (orig_cnt_q < 6'(ORIG_BITS)) begin
                    data_out_d = ORIG_ROM[6'(ORIG_BITS - 1) - orig_cnt_q];
                    orig_cnt_d = orig_cnt_q + 6'd1;
                    if (orig_cnt_q == 6'(ORIG_BITS - 1)) begin
                        sort_finish_d = 1'b1;
                    end
                end
            end else begin
                data_out_d = sub_active ? sub_bit : dly_q[DLY-1];
                if (rx_valid) begin
                    if (!sort_finish_q) begin
                        // First valid frame: ID_layer is judged against the new ID
                        own_id_d      = next_id(rx_frame_ia);
                        sort_finish_d = 1'b1;
                        if (rx_id_layer == next_id(rx_frame_ia)) begin
                            power_reg_d = rx_power;
                        end
                    end else if (rx_id_layer == own_id_q) begin
                        power_reg_d = rx_power;
                    end
                end
            end
        end
    end

    // Mode strap is sampled once, on the first edge after reset release
    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_valid_q <= 1'b0;
            is_first_q   <= 1'b0;
        end else if (!mode_valid_q) begin
            mode_valid_q <= 1'b1;
            is_first_q   <= f_layer;
        end
    end

    // Forwarding delay line
    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            dly_q <= '0;
        end else begin
            dly_q <= {dly_q[DLY-2:0], data_in};
        end
    end

    // Registered outputs and layer state
    always_ff @(posedge t_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out_q    <= 1'b0;
            sort_finish_q <= 1'b0;
            own_id_q      <= 4'd0;
            power_reg_q   <= 4'd0;
            orig_cnt_q    <= 6'd0;
        end else begin
            data_out_q    <= data_out_d;
            sort_finish_q <= sort_finish_d;
            own_id_q      <= own_id_d;
            power_reg_q   <= power_reg_d;
            orig_cnt_q    <= orig_cnt_d;
        end
    end

    assign data_out    = data_out_q;
    assign sort_finish = sort_finish_q;

endmodule

// File: tb/tb_self_test_top.sv
// Self-checking bench for self_test_top: builds bit streams, predicts the
// outputs with a frame-level reference model and compares every edge.
module tb_self_test_top;

    localparam int          MAXN    = 1024;
    localparam logic [15:0] T_SYNC  = 16'h0DF0;
    localparam logic [3:0]  T_PASS  = 4'hA;
    localparam logic [15:0] T_TAIL  = 16'hBEAF;

    logic t_clk   = 1'b0;
    logic rst_n   = 1'b0;
    logic f_layer = 1'b0;
    logic data_in = 1'b0;
    logic sort_finish;
    logic data_out;

    self_test_top dut (
        .t_clk       (t_clk),
        .rst_n       (rst_n),
        .f_layer     (f_layer),
        .data_in     (data_in),
        .sort_finish (sort_finish),
        .data_out    (data_out)
    );

    always #5 t_clk = ~t_clk;

    bit         stim     [MAXN];
    bit         exp_out  [MAXN];
    bit         exp_sort [MAXN];
    bit         exp_frame[MAXN];
    logic [3:0] exp_own  [MAXN];
    logic [3:0] exp_pw   [MAXN];
    int         len;
    int         cur_edge;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @edge %0d: got %0h, expected %0h", tag, cur_edge, got, exp);
        end
    endtask

    task automatic push_bits(input logic [31:0] v, input int w);
        for (int b = w - 1; b >= 0; b--) begin
            stim[len] = v[b];
            len++;
        end
    endtask

    task automatic push_frame(input logic [3:0] p, input logic [3:0] ps, input logic [3:0] ia,
                              input logic [3:0] il, input logic [15:0] tr);
        logic [31:0] w;
        w = {p, ps, ia, il, tr};
        push_bits(w, 32);
    endtask

    // Last 16 stream bits ending at index i (bits before the stream are 0)
    function automatic logic [15:0] win16(input int i);
        logic [15:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) begin
            int idx;
            idx = i - 15 + k;
            w = {w[14:0], (idx >= 0) ? stim[idx] : 1'b0};
        end
        return w;
    endfunction

    // Reference model: index e is the bit sampled by edge e; arrays hold the
    // values expected just after that edge.
    task automatic build_model(input int n, input bit first);
        for (int e = 0; e < n; e++) begin
            exp_out[e]   = 1'b0;
            exp_sort[e]  = 1'b0;
            exp_frame[e] = 1'b0;
            exp_own[e]   = 4'd0;
            exp_pw[e]    = 4'd0;
        end
        if (first) begin
            logic [47:0] rom;
            rom = {T_SYNC, T_PASS, 4'h0, 4'h0, 4'h1, T_TAIL};
            for (int j = 0; j < 48; j++) if (1 + j < n) exp_out[1 + j] = rom[47 - j];
            for (int e = 48; e < n; e++) exp_sort[e] = 1'b1;
        end else begin
            bit         sorted;
            bit         in_frame;
            logic [3:0] own, pw;
            int         i, start;
            sorted = 0; own = 0; pw = 0; in_frame = 0; i = 0; start = 0;
            for (int e = 5; e < n; e++) exp_out[e] = stim[e - 5];
            while (i < n) begin
                if (!in_frame) begin
                    if (win16(i) == T_SYNC) begin
                        in_frame = 1;
                        start    = i + 1;
                        for (int e = i; e < n; e++) exp_frame[e] = 1'b1;
                    end
                    i++;
                end else begin
                    logic [31:0] word;
                    logic [3:0]  sub;
                    int          e_end;
                    if (start + 31 >= n) break;
                    word = '0;
                    for (int k = 0; k < 32; k++) word = {word[30:0], stim[start + k]};
                    e_end = start + 31;
                    if (word[31:28] == T_PASS) begin
                        sub = sorted ? own : word[23:20] + 4'd1;
                        for (int j = 0; j < 4; j++)
                            if (start + 13 + j < n) exp_out[start + 13 + j] = sub[3 - j];
                    end
                    if (word[31:28] == T_PASS && word[15:0] == T_TAIL) begin
                        if (!sorted) begin
                            sorted = 1;
                            own    = word[23:20] + 4'd1;
                        end
                        if (word[19:16] == own) pw = word[27:24];
                        for (int e = e_end; e < n; e++) begin
                            exp_sort[e] = sorted;
                            exp_own[e]  = own;
                            exp_pw[e]   = pw;
                        end
                        start = e_end + 1;
                    end else begin
                        in_frame = 0;
                        for (int e = e_end; e < n; e++) exp_frame[e] = 1'b0;
                    end
                    i = e_end + 1;
                end
            end
        end
    endtask

    task automatic apply_reset(input bit first);
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            data_in = 1'($urandom);
            f_layer = 1'($urandom);
            @(posedge t_clk); #1;
            cur_edge = -1;
            check_eq("rst_data_out", data_out, 0);
            check_eq("rst_sort_finish", sort_finish, 0);
            @(negedge t_clk);
        end
        f_layer = first;
        data_in = 1'b0;
        rst_n   = 1'b1;
    endtask

    task automatic run_stream(input string name, input int n, input bit first, input int abort_at);
        build_model(n, first);
        apply_reset(first);
        for (int e = 0; e < n; e++) begin
            data_in = first ? 1'($urandom) : stim[e];
            if (e == 1) f_layer = !first;
            @(posedge t_clk); #1;
            cur_edge = e;
            check_eq("data_out", data_out, exp_out[e]);
            check_eq("sort_finish", sort_finish, exp_sort[e]);
            check_eq("own_id", dut.own_id_q, exp_own[e]);
            check_eq("power_reg", dut.power_reg_q, exp_pw[e]);
            if (!first)
                check_eq("rx_state", dut.u_rx.state_q,
                         exp_frame[e] ? self_test_pkg::FRAME : self_test_pkg::HUNT);
            if (e == abort_at) begin
                @(negedge t_clk);
                rst_n = 1'b0;
                #1;
                check_eq("async_clr_sort", sort_finish, 0);
                check_eq("async_clr_out", data_out, 0);
                check_eq("async_clr_own", dut.own_id_q, 0);
                check_eq("async_clr_pw", dut.power_reg_q, 0);
                $display("stream %s: aborted by reset after edge %0d, sort=%0d own=%0d pw=%0d",
                         name, e, exp_sort[e], exp_own[e], exp_pw[e]);
                return;
            end
            @(negedge t_clk);
        end
        $display("stream %s: %0d bits, final sort=%0d own=%0d pw=%0d",
                 name, n, exp_sort[n-1], exp_own[n-1], exp_pw[n-1]);
    endtask

    task automatic gen_random();
        len = 0;
        while (len < 450) begin
            int nf;
            push_bits($urandom, $urandom_range(0, 20));
            push_bits(32'(T_SYNC), 16);
            nf = $urandom_range(1, 4);
            for (int f = 0; f < nf; f++) begin
                logic [3:0]  p, ps, ia, il;
                logic [15:0] tr;
                p  = ($urandom_range(0, 5) == 0) ? 4'($urandom) : T_PASS;
                ps = 4'($urandom);
                ia = $urandom_range(0, 1) ? 4'd0 : 4'($urandom);
                il = $urandom_range(0, 1) ? ia + 4'd1 : 4'($urandom);
                tr = ($urandom_range(0, 5) == 0) ? (T_TAIL ^ (16'd1 << $urandom_range(0, 15))) : T_TAIL;
                push_frame(p, ps, ia, il, tr);
            end
        end
    endtask

    initial begin
        // Directed sort and forwarding, then trailing ones drop back to HUNT
        len = 0;
        push_bits(32'h0, 3);
        push_bits(32'(T_SYNC), 16);
        for (int p = 2; p <= 5; p++) push_frame(T_PASS, 4'(p), 4'h0, 4'h1, T_TAIL);
        push_bits(32'hFFFF_FFFF, 32);
        push_bits(32'hFF, 8);
        run_stream("sort", len, 1'b0, -1);

        // Corrupted trailer is rejected, a later SYNC + frame still sorts
        len = 0;
        push_bits(32'(T_SYNC), 16);
        push_frame(T_PASS, 4'h2, 4'h0, 4'h1, 16'hBEAE);
        push_bits(32'h0, 5);
        push_bits(32'(T_SYNC), 16);
        push_frame(T_PASS, 4'h7, 4'h0, 4'h1, T_TAIL);
        push_bits(32'h0, 10);
        run_stream("bad_trailer", len, 1'b0, -1);

        // ID wraps F -> 0
        len = 0;
        push_bits(32'(T_SYNC), 16);
        push_frame(T_PASS, 4'h4, 4'hF, 4'h0, T_TAIL);
        push_frame(T_PASS, 4'h9, 4'h3, 4'h0, T_TAIL);
        push_bits(32'h0, 8);
        run_stream("id_wrap", len, 1'b0, -1);

        // Bottom layer originates its own stream
        len = 0;
        run_stream("originator", 70, 1'b1, -1);

        // Reset at bit 20 of the second frame, then a clean re-send
        len = 0;
        push_bits(32'(T_SYNC), 16);
        push_frame(T_PASS, 4'h2, 4'h0, 4'h1, T_TAIL);
        push_frame(T_PASS, 4'h3, 4'h0, 4'h1, T_TAIL);
        run_stream("mid_reset", len, 1'b0, 16 + 32 + 20);
        len = 0;
        push_bits(32'(T_SYNC), 16);
        push_frame(T_PASS, 4'h6, 4'h0, 4'h1, T_TAIL);
        push_bits(32'h0, 6);
        run_stream("resend", len, 1'b0, -1);

        // Randomized streams
        for (int r = 0; r < 6; r++) begin
            gen_random();
            run_stream($sformatf("random%0d", r), len, 1'b0, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
